// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode, FSM-state and register-number definitions shared by
//               the alu_exec execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int REGNUM_W = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/mul_shift_add.sv
`default_nettype none
// ============================================================================
// Module      : mul_shift_add
// Description : Iterative WIDTH x WIDTH unsigned shift-add multiplier, one
//               partial product per step, sequenced by the parent FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_shift_add #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 step,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] step_prod;

    // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    always_comb begin
        sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        step_prod = {sum, prod_q[WIDTH-1:1]};
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        if (load) begin
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
            cnt_d   = '0;
        end else if (step) begin
            prod_d  = step_prod;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // product is the post-step value so the parent can register it on the final step edge.
    assign product = step_prod;
    assign last    = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : mul_shift_add
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec
// Description : 8-bit execute stage: single-cycle ALU ops plus an iterative
//               MUL, driving the register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic [REGNUM_W-1:0]  dest_in,
    output logic                 busy,
    output logic [WIDTH-1:0]     result_out,
    output logic [WIDTH-1:0]     mul_high_out,
    output logic [REGNUM_W-1:0]  dest_out,
    output logic                 write_en,
    output logic                 zero_flag,
    output logic                 carry_flag
);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [WIDTH-1:0]    mul_high_q, mul_high_d;
    logic [REGNUM_W-1:0] dest_q, dest_d;
    logic [REGNUM_W-1:0] mul_dest_q, mul_dest_d;
    logic                write_en_q, write_en_d;
    logic                zero_q, zero_d;
    logic                carry_q, carry_d;

    logic [WIDTH-1:0]    alu_res;
    logic                alu_carry;
    logic                mul_load, mul_step, mul_last;
    logic [2*WIDTH-1:0]  mul_product;

    mul_shift_add #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (mul_load),
        .a       (a_in),
        .b       (b_in),
        .step    (mul_step),
        .product (mul_product),
        .last    (mul_last)
    );

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            OP_ADD: {alu_carry, alu_res} = {1'b0, a_in} + {1'b0, b_in};
            OP_SUB: begin
                alu_res   = a_in - b_in;
                alu_carry = (a_in < b_in);
            end
            OP_AND: alu_res = a_in & b_in;
            OP_OR:  alu_res = a_in | b_in;
            OP_XOR: alu_res = a_in ^ b_in;
            OP_SHL: begin
                alu_res   = {a_in[WIDTH-2:0], 1'b0};
                alu_carry = a_in[WIDTH-1];
            end
            OP_SHR: begin
                alu_res   = {1'b0, a_in[WIDTH-1:1]};
                alu_carry = a_in[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        mul_high_d = mul_high_q;
        dest_d     = dest_q;
        mul_dest_d = mul_dest_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        write_en_d = 1'b0;
        mul_load   = 1'b0;
        mul_step   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mul_load   = 1'b1;
                        mul_dest_d = dest_in;
                        state_d    = ST_MUL;
                    end else begin
                        result_d   = alu_res;
                        zero_d     = (alu_res == '0);
                        carry_d    = alu_carry;
                        dest_d     = dest_in;
                        write_en_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // start is deliberately ignored here; there is no issue queue.
                mul_step = 1'b1;
                if (mul_last) begin
                    result_d   = mul_product[WIDTH-1:0];
                    mul_high_d = mul_product[2*WIDTH-1:WIDTH];
                    zero_d     = (mul_product == '0);
                    carry_d    = (mul_product[2*WIDTH-1:WIDTH] != '0);
                    dest_d     = mul_dest_q;
                    write_en_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            result_q   <= '0;
            mul_high_q <= '0;
            dest_q     <= '0;
            mul_dest_q <= '0;
            write_en_q <= 1'b0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            mul_high_q <= mul_high_d;
            dest_q     <= dest_d;
            mul_dest_q <= mul_dest_d;
            write_en_q <= write_en_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
        end
    end

    assign busy         = (state_q == ST_MUL);
    assign result_out   = result_q;
    assign mul_high_out = mul_high_q;
    assign dest_out     = dest_q;
    assign write_en     = write_en_q;
    assign zero_flag    = zero_q;
    assign carry_flag   = carry_q;

endmodule : alu_exec
`default_nettype wire
